// File: rtl/ysyx_22040088_dmem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory responder.
package ysyx_22040088_dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-lane strobe for an access of the given size starting at lane off.
    function automatic logic [7:0] size_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] lanes;
        case (size)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << off;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            SZ_B:    mask = 64'h0000_0000_0000_00FF;
            SZ_H:    mask = 64'h0000_0000_0000_FFFF;
            SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22040088_dmem_array.sv
// DEPTH x 64 storage: combinational read, byte-enable registered write, no reset.
module ysyx_22040088_dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       strb,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata_c
);

    logic [63:0] mem [DEPTH];

    assign rdata_c = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_22040088_dmem_resp.sv
// Latency-configurable data-memory responder with valid/ready request and response channels.
// Define DMEM_MISALIGN_CHK_EN to fault misaligned accesses instead of force-aligning them.
module ysyx_22040088_dmem_resp
    import ysyx_22040088_dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [64:0] SPAN  = 65'(DEPTH) << 3;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wen_q;
    logic [1:0]         op_size_q;
    logic [63:0]        op_addr_q, op_wdata_q;
    logic               rsp_valid_d, rsp_err_d, req_ready_d;
    logic [63:0]        rsp_rdata_d;
    logic               cap_en, commit;

    logic               op_wen;
    logic [1:0]         op_size;
    logic [63:0]        op_addr, op_wdata;
    logic [63:0]        lo_mask, eff_addr, ofs, word_rd, load_data;
    logic [3:0]         nbytes;
    logic [2:0]         off;
    logic               align_err, in_range, acc_err, arr_we;
    logic [IDX_W-1:0]   idx;

    // A LATENCY=1 commit happens on the acceptance edge, so the live request is used in IDLE.
    always_comb begin
        op_wen   = (state_q == IDLE) ? req_wen   : op_wen_q;
        op_size  = (state_q == IDLE) ? req_size  : op_size_q;
        op_addr  = (state_q == IDLE) ? req_addr  : op_addr_q;
        op_wdata = (state_q == IDLE) ? req_wdata : op_wdata_q;
    end

    always_comb begin
        lo_mask = (64'd1 << op_size) - 64'd1;
        nbytes  = 4'd1 << op_size;
`ifdef DMEM_MISALIGN_CHK_EN
        eff_addr  = op_addr;
        align_err = |(op_addr & lo_mask);
`else
        eff_addr  = op_addr & ~lo_mask;
        align_err = 1'b0;
`endif
        ofs       = eff_addr - BASE;
        in_range  = (eff_addr >= BASE) && (({1'b0, ofs} + 65'(nbytes)) <= SPAN);
        acc_err   = align_err | ~in_range;
        off       = eff_addr[2:0];
        idx       = ofs[3 +: IDX_W];
        load_data = (word_rd >> {off, 3'b000}) & size_mask(op_size);
    end

    ysyx_22040088_dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .strb    (size_strb(op_size, off)),
        .idx     (idx),
        .wdata   (op_wdata << {off, 3'b000}),
        .rdata_c (word_rd)
    );

    // Next-state and response logic; commit marks the edge entering RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        cap_en      = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cap_en = 1'b1;
                    if (LATENCY <= 1) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) commit = 1'b1;
                else                    cnt_d  = cnt_q - CNT_W'(1);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            state_d     = RESP;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || op_wen) ? 64'd0 : load_data;
        end
        arr_we      = commit & op_wen & ~acc_err;
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
            req_ready  <= 1'b0;
            op_wen_q   <= 1'b0;
            op_size_q  <= 2'd0;
            op_addr_q  <= 64'd0;
            op_wdata_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            req_ready <= req_ready_d;
            if (cap_en) begin
                op_wen_q   <= req_wen;
                op_size_q  <= req_size;
                op_addr_q  <= req_addr;
                op_wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_dmem_resp.sv
// Bench for ysyx_22040088_dmem_resp: directed table, corner sequences, random vs byte-level model.
module tb_ysyx_22040088_dmem_resp;
    import ysyx_22040088_dmem_pkg::*;

    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    ysyx_22040088_dmem_resp #(
        .DEPTH   (DEPTH),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte-addressed reference: each byte of the access is located and moved independently.
    function automatic void model(input logic wen, input logic [1:0] size, input logic [63:0] addr,
                                  input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        int unsigned n = 1 << size;
        logic [63:0] a;
        rdata = 64'd0;
        err   = 1'b0;
        if (CHK) begin
            a = addr;
            if (addr % n != 0) err = 1'b1;
        end else begin
            a = addr - (addr % n);
        end
        if (a < BASE || ({1'b0, a - BASE} + 65'(n)) > {1'b0, SPAN}) err = 1'b1;
        if (!err) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [63:0] ba;
                int w, l;
                ba = a - BASE + 64'(i);
                w  = int'(ba >> 3);
                l  = int'(ba[2:0]);
                if (wen) ref_mem[w][8*l +: 8] = wdata[8*i +: 8];
                else     rdata[8*i +: 8]      = ref_mem[w][8*l +: 8];
            end
        end
    endfunction

    function automatic void add(input logic wen, input logic [1:0] size, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vt.push_back(v);
    endfunction

    // One full transaction; bp = cycles rsp_ready is held low after rsp_valid rises.
    task automatic do_req(input logic wen, input logic [1:0] size, input logic [63:0] addr,
                          input logic [63:0] wdata, input int bp,
                          output logic [63:0] rdata, output logic err, output int lat, output bit ok);
        int n;
        ok = 1'b1; lat = 0; rdata = 64'd0; err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
        rsp_ready = (bp == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            ok = 1'b0;
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rdata", rsp_rdata, rdata);
            check("bp_err",   64'(rsp_err), 64'(err));
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, mrd;
        logic        er, mer;
        int          lat, n;
        bit          ok;

        rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b1;

        // Directed table: test-plan transactions in order.
        add(1, SZ_D, 64'h8000_0000, 64'h1122_3344_5566_7788, 64'd0, 0);
        add(0, SZ_D, 64'h8000_0000, 64'd0, 64'h1122_3344_5566_7788, 0);
        add(1, SZ_B, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 0);
        add(0, SZ_D, 64'h8000_0000, 64'd0, 64'h1122_AB44_5566_7788, 0);
        add(0, SZ_B, 64'h8000_0005, 64'd0, 64'h0000_0000_0000_00AB, 0);
        add(0, SZ_H, 64'h8000_0006, 64'd0, 64'h0000_0000_0000_1122, 0);
        add(0, SZ_W, 64'h8000_0004, 64'd0, 64'h0000_0000_1122_AB44, 0);
        add(1, SZ_D, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
        add(0, SZ_D, 64'h8000_1FF8, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
        add(0, SZ_W, 64'h7FFF_FFFC, 64'd0, 64'd0, 1);
        add(1, SZ_D, BASE + SPAN,   64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1);
        add(0, SZ_D, 64'h8000_0000, 64'd0, 64'h1122_AB44_5566_7788, 0);
        add(0, SZ_D, 64'h8000_1FF8, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
        add(0, SZ_B, BASE + SPAN,   64'd0, 64'd0, 1);
        add(0, SZ_B, 64'h8000_1FFF, 64'd0, 64'h0000_0000_0000_0001, 0);
        add(1, SZ_H, 64'h8000_0003, 64'h0000_0000_0000_CAFE, 64'd0, CHK);
        add(0, SZ_D, 64'h8000_0000, 64'd0,
            CHK ? 64'h1122_AB44_5566_7788 : 64'h1122_AB44_CAFE_7788, 0);
        add(0, SZ_W, 64'h8000_1FFE, 64'd0, CHK ? 64'd0 : 64'h0000_0000_0123_4567, CHK);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err",   64'(rsp_err), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_req_ready", 64'(req_ready), 64'd1);

        foreach (vt[i]) begin
            model(vt[i].wen, vt[i].size, vt[i].addr, vt[i].wdata, mrd, mer);
            do_req(vt[i].wen, vt[i].size, vt[i].addr, vt[i].wdata, 0, rd, er, lat, ok);
            check($sformatf("vec%0d_done", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
            if (!vt[i].wen || vt[i].exp_err)
                check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        end

        // Back-pressured store, then readback of the merged word
        model(1, SZ_W, 64'h8000_0000, 64'h0000_0000_5A5A_5A5A, mrd, mer);
        do_req(1, SZ_W, 64'h8000_0000, 64'h0000_0000_5A5A_5A5A, 5, rd, er, lat, ok);
        check("bp_done", 64'(ok), 64'd1);
        check("bp_store_err", 64'(er), 64'd0);
        do_req(0, SZ_D, 64'h8000_0000, 64'd0, 0, rd, er, lat, ok);
        check("bp_readback", rd, CHK ? 64'h1122_AB44_5A5A_5A5A : 64'h1122_AB44_5A5A_5A5A);

        // Reset during WAIT drops an uncommitted store
        model(1, SZ_D, 64'h8000_0008, 64'h0BAD_F00D_1234_5678, mrd, mer);
        do_req(1, SZ_D, 64'h8000_0008, 64'h0BAD_F00D_1234_5678, 0, rd, er, lat, ok);
        check("prefill_done", 64'(ok), 64'd1);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_size = SZ_D;
        req_addr = 64'h8000_0008; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstw_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rstw_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstw_ready_back", 64'(req_ready), 64'd1);
        check("rstw_no_rsp", 64'(rsp_valid), 64'd0);
        do_req(0, SZ_D, 64'h8000_0008, 64'd0, 0, rd, er, lat, ok);
        check("rstw_word_kept", rd, 64'h0BAD_F00D_1234_5678);

        // Random traffic against the reference model
        for (int w = 0; w < 8; w++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            model(1, SZ_D, BASE + 64'(8*w), d, mrd, mer);
            do_req(1, SZ_D, BASE + 64'(8*w), d, 0, rd, er, lat, ok);
        end
        for (int t = 0; t < 150; t++) begin
            logic        wen;
            logic [1:0]  size;
            logic [63:0] addr, wdata;
            int          sel, bp;
            wen   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            wdata = {$urandom, $urandom};
            sel   = $urandom_range(0, 15);
            if (sel == 0)      addr = BASE - 64'($urandom_range(1, 8));
            else if (sel == 1) addr = BASE + SPAN - 64'($urandom_range(0, 7));
            else               addr = BASE + 64'($urandom_range(0, 63));
            bp = $urandom_range(0, 2);
            model(wen, size, addr, wdata, mrd, mer);
            do_req(wen, size, addr, wdata, bp, rd, er, lat, ok);
            check($sformatf("rnd%0d_done", t), 64'(ok), 64'd1);
            check($sformatf("rnd%0d_err", t), 64'(er), 64'(mer));
            check($sformatf("rnd%0d_lat", t), 64'(lat), 64'(LAT));
            if (!wen || mer) check($sformatf("rnd%0d_rdata", t), rd, mrd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
